// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold: a winner keeps the resource until done, request drop or hold timeout.
// Latency: request seen at an edge is granted at that edge; one idle cycle always follows a release.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_nxt;
  logic [N-1:0]      gnt_q, gnt_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic [ID_W-1:0]   last_q, last_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              busy_q, busy_nxt;
  logic              to_q, to_nxt;

  logic [ID_W-1:0]   winner;
  logic              found;
  logic [ID_W-1:0]   cand;

  // Rotating search starting just after the previous winner, wrapping modulo N.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = ID_W'((int'(last_q) + i) % N);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    id_nxt    = id_q;
    last_nxt  = last_q;
    cnt_nxt   = cnt_q;
    busy_nxt  = busy_q;
    to_nxt    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << winner;
          id_nxt    = winner;
          last_nxt  = winner;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (done || !req[id_q] || cnt_q == CNT_LAST) begin
          // Timeout only flags when neither done nor a dropped request explains the release.
          to_nxt    = !done && req[id_q];
          state_nxt = IDLE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      last_q  <= PTR_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      id_q    <= id_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
      busy_q  <= busy_nxt;
      to_q    <= to_nxt;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: directed scenarios plus random traffic against an ownership-level model.
module tb_rr_hold_arbiter;
  localparam int N = 4;
  localparam int ID_W = 2;
  localparam int MAX_HOLD = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  int checks = 0;
  int failures = 0;

  // Model: who owns the resource, for how many cycles, and who won last.
  bit m_busy;
  int m_owner;
  int m_cycles;
  int m_last;
  int m_id;
  bit m_to;

  rr_hold_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_busy) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic cycle(input logic [N-1:0] r, input logic d, input logic rn);
    req = r; done = d; rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_cycles = 0; m_last = N - 1; m_id = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (r != 0) begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last + i) % N;
          if (!m_busy && r[c]) begin
            m_busy = 1; m_owner = c; m_id = c; m_last = c; m_cycles = 1;
          end
        end
      end
    end else if (d || !r[m_owner]) begin
      m_busy = 0; m_to = 0;
    end else if (m_cycles == MAX_HOLD) begin
      m_busy = 0; m_to = 1;
    end else begin
      m_cycles++;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(4'b0000, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset: gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt, gnt_id, busy, timeout);
    end
  endtask

  task automatic test_single();
    cycle(4'b1000, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
    end
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b0, 1'b1);
    cycle(4'b1000, 1'b1, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL single_done: gnt=%b busy=%b to=%b id=%0d, want 0000/0/0/3", gnt, busy, timeout, gnt_id);
    end
  endtask

  task automatic test_fairness();
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] exp;
      exp = 4'b0001 << (k % 4);
      cycle(4'b1111, 1'b0, 1'b1);
      checks++;
      if (gnt !== exp || gnt_id !== ID_W'(k % 4)) begin
        failures++;
        $display("FAIL fairness_grant%0d: gnt=%b id=%0d, want %b/%0d", k, gnt, gnt_id, exp, k % 4);
      end
      cycle(4'b1111, 1'b0, 1'b1);
      cycle(4'b1111, 1'b1, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL fairness_idle%0d: gnt=%b busy=%b, want 0000/0", k, gnt, busy);
      end
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] reqs [3];
    int           exps [3];
    reqs[0] = 4'b1010; reqs[1] = 4'b1010; reqs[2] = 4'b0010;
    exps[0] = 3; exps[1] = 1; exps[2] = 1;
    cycle(4'b0010, 1'b0, 1'b1);  // establishes last=1
    cycle(4'b0010, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(reqs[k], 1'b0, 1'b1);
      checks++;
      if (gnt_id !== ID_W'(exps[k]) || gnt !== (4'b0001 << exps[k])) begin
        failures++;
        $display("FAIL rotation%0d: gnt=%b id=%0d, want id %0d", k, gnt, gnt_id, exps[k]);
      end
      cycle(reqs[k], 1'b1, 1'b1);
    end
  endtask

  task automatic test_timeout();
    int high;
    high = 0;
    for (int k = 0; k < MAX_HOLD; k++) begin
      cycle(4'b0100, 1'b0, 1'b1);
      if (gnt === 4'b0100 && timeout === 1'b0) high++;
    end
    checks++;
    if (high != MAX_HOLD) begin
      failures++;
      $display("FAIL timeout_hold: cycles_high=%0d, want %0d", high, MAX_HOLD);
    end
    cycle(4'b0100, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: gnt=%b to=%b, want 0000/1", gnt, timeout);
    end
    cycle(4'b0100, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant: gnt=%b to=%b, want 0100/0", gnt, timeout);
    end
    for (int k = 1; k < MAX_HOLD; k++) cycle(4'b0110, 1'b0, 1'b1);
    cycle(4'b0110, 1'b0, 1'b1);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse2: to=%b, want 1", timeout);
    end
    cycle(4'b0110, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      failures++;
      $display("FAIL timeout_rotate: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
    end
    cycle(4'b0110, 1'b1, 1'b1);
  endtask

  task automatic test_owner_drop();
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: gnt=%b busy=%b to=%b, want 0000/0/0", gnt, busy, timeout);
    end
    cycle(4'b0100, 1'b0, 1'b1);
    for (int k = 1; k < MAX_HOLD; k++) cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b0100, 1'b1, 1'b1);  // done coincides with hold expiry
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL done_vs_expiry: gnt=%b to=%b, want 0000/0", gnt, timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b1110, 1'b0, 1'b1);
    cycle(4'b1110, 1'b0, 1'b0);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL midgrant_reset: gnt=%b busy=%b to=%b id=%0d, want 0000/0/0/0", gnt, busy, timeout, gnt_id);
    end
    cycle(4'b1110, 1'b0, 1'b1);
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      failures++;
      $display("FAIL midgrant_pointer: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
    end
    cycle(4'b1110, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      cycle(r, $urandom_range(0, 5) == 0, $urandom_range(0, 99) != 0);
      checks++;
      if (gnt !== m_gnt() || busy !== m_busy || timeout !== m_to || gnt_id !== ID_W'(m_id)
          || (timeout && gnt != 0)) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random%0d: gnt=%b id=%0d busy=%b to=%b, want %b/%0d/%b/%b",
                   k, gnt, gnt_id, busy, timeout, m_gnt(), m_id, m_busy, m_to);
      end
    end
  endtask

  initial begin
    req = '0; done = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_rotation();
    test_timeout();
    test_owner_drop();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_hold_arbiter.md
Name: rr_hold_arbiter

Overview:
- Round-robin arbiter with grant hold, sharing one resource (bus or engine port) between N requesters.
- A winner keeps its grant until it signals done, drops its request, or hits a hold timeout.
- Rotating priority gives the last winner the lowest priority on the next decision.
- Sits between requester blocks and the shared resource. Drives the one-hot grant and the encoded owner ID used by the resource mux.

Parameters:
- N, 4, number of requesters (2..16).
- ID_W, 2, width of gnt_id; must equal ceil(log2(N)).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (2..255).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  per-requester request, level-sensitive.
- done  input  1  current owner finished; sampled only in GRANT.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of current owner; valid when busy=1.
- busy  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse when an ownership ends by hold timeout.

Behaviour:
- Reset, sampled at a rising edge with rst_n=0:
  - gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, state=IDLE.
  - last pointer=N-1, so the first priority order is 0,1,...,N-1.
- Reset mid-grant: outputs take reset values at that edge, with no timeout pulse.
- State IDLE:
  - At an edge with req!=0, the winner is the first set bit searching from last+1 upward, wrapping modulo N.
  - At that edge: gnt=onehot(winner), gnt_id=winner, busy=1, last=winner, hold_cnt=0, state=GRANT.
  - Latency: req seen at edge k gives gnt high from edge k onward, visible in cycle k+1.
  - With req=0, remain IDLE and outputs stay 0.
- State GRANT: at each edge, evaluate release conditions in this priority order:
  1. done=1 -> release, timeout stays 0.
  2. req[gnt_id]=0 -> release, timeout stays 0.
  3. hold_cnt==MAX_HOLD-1 -> release, timeout=1 for exactly the next cycle.
  4. Otherwise hold_cnt+=1 and gnt stays unchanged.
- Release: at the release edge gnt=0, busy=0, hold_cnt=0, state=IDLE; gnt_id keeps its last value.
- One mandatory idle cycle follows every release, so there is no back-to-back handoff. Re-arbitration happens at the following edge.
- Max ownership: MAX_HOLD cycles of gnt high.
- A timed-out owner still requesting gets lowest priority next round. If it is the sole requester, it is re-granted after the idle cycle.
- Requests from non-owners during GRANT are ignored until IDLE. Requests are not latched; a request dropped before the decision edge is lost.
- gnt is always zero or one-hot. busy==|gnt at all times.
- timeout is never high in the same cycle as gnt.
- hold_cnt width is ceil(log2(MAX_HOLD)) bits and never wraps.

Test Plan:
- Reset then single request: rst_n=0 for 1 edge, then req=4'b1000. gnt=4'b1000 and gnt_id=3 one cycle later. done pulse after 3 grant cycles -> gnt=0 next cycle; timeout stays 0.
- Fairness under full load: req=4'b1111 held, done pulsed 2 cycles into each grant. Grant sequence is 0,1,2,3,0, each grant separated by exactly one idle cycle.
- Rotation with gaps: after last=1, req=4'b1010 -> grant 3. Next round with 4'b1010 -> grant 1. Next round with 4'b0010 -> grant 1.
- Timeout: req=4'b0100 held, done=0. gnt=4'b0100 for exactly 8 cycles, then gnt=0 with timeout=1 for one cycle, then re-granted to 2. Repeat with req=4'b0110 -> second grant goes to 1.
- Owner drop and priority: owner 2 drops req while done=0 -> release next edge, timeout=0. done and hold expiry on the same edge -> timeout=0.
- Reset mid-grant: rst_n=0 during grant to 1 with req=4'b1110. Next edge gives gnt=0, busy=0, timeout=0. After rst_n=1 with req=4'b1110, first grant goes to 1 (pointer reset).
